// File: rtl/accel_host_sequencer.sv
// Initiator side of the accelerator start/ready handshake: takes one operand per job,
// sequences accel_start, waits for the result and offers it downstream; hangs raise a sticky err.
module accel_host_sequencer #(
  parameter int unsigned XW           = 16,
  parameter int unsigned RW           = 16,
  parameter int unsigned START_CYCLES = 1,
  parameter int unsigned ACK_LIMIT    = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_data,
  output logic          accel_start,
  output logic [XW-1:0] accel_x,
  input  logic          accel_ready,
  input  logic [RW-1:0] accel_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          err
);

  localparam int unsigned SCW = $clog2(START_CYCLES + 1);
  localparam int unsigned ACW = $clog2(ACK_LIMIT + 1);
  localparam int unsigned BCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITRDY = 3'd1,
    S_START   = 3'd2,
    S_ACK     = 3'd3,
    S_BUSY    = 3'd4,
    S_OUT     = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [SCW-1:0] start_cnt_q, start_cnt_d;
  logic [ACW-1:0] ack_cnt_q, ack_cnt_d;
  logic [BCW-1:0] busy_cnt_q, busy_cnt_d;
  logic           accel_start_q, accel_start_d;
  logic [XW-1:0]  accel_x_q, accel_x_d;
  logic           out_valid_q, out_valid_d;
  logic [RW-1:0]  out_data_q, out_data_d;
  logic           err_q, err_d;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    accel_x_d   = accel_x_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accel_x_d = in_data;
          state_d   = accel_ready ? S_START : S_WAITRDY;
        end
      end
      S_WAITRDY: begin
        if (accel_ready) state_d = S_START;
      end
      S_START: begin
        if (start_cnt_q == SCW'(START_CYCLES - 1)) state_d = S_ACK;
        else start_cnt_d = start_cnt_q + SCW'(1);
      end
      S_ACK: begin
        // Ready may already be low on entry: the controller drops it right after sampling start
        if (!accel_ready) begin
          state_d = S_BUSY;
        end else if (ack_cnt_q == ACW'(ACK_LIMIT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACW'(1);
        end
      end
      S_BUSY: begin
        if (accel_ready) begin
          out_data_d  = accel_result;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (busy_cnt_q == BCW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + BCW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      start_cnt_d = '0;
      ack_cnt_d   = '0;
      busy_cnt_d  = '0;
    end

    accel_start_d = (state_d == S_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_cnt_q   <= '0;
      ack_cnt_q     <= '0;
      busy_cnt_q    <= '0;
      accel_start_q <= 1'b0;
      accel_x_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_cnt_q   <= start_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
      busy_cnt_q    <= busy_cnt_d;
      accel_start_q <= accel_start_d;
      accel_x_q     <= accel_x_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      err_q         <= err_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign accel_start = accel_start_q;
  assign accel_x     = accel_x_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign err         = err_q;

endmodule
